// File: rtl/cdr_pkg.sv
`default_nettype none
// ============================================================================
// Module : cdr_pkg
// Brief  : Shared definitions for the oversampling clock/data recovery block.
//          Holds parameter defaults, the majority-vote helper and the
//          encoding of the phase-correction decision {up, down}.
// Rev    : 1.0  initial release
// ============================================================================
package cdr_pkg;

    // Parameter defaults
    localparam int c_BIT_CLKS_DEFAULT = 999;
    localparam int c_NSAMP_DEFAULT    = 3;
    localparam int c_STEP_DEFAULT     = 111;
    localparam int c_LOCK_CNT_DEFAULT = 16;

    // Widest supported sample window; the vote helper works on this width
    localparam int c_MAX_NSAMP = 7;
    localparam int c_SAMP_W    = 8;

    // Phase decision encoding: bit1 = up (shorten), bit0 = down (lengthen)
    localparam logic [1:0] c_PHASE_NONE = 2'b00;
    localparam logic [1:0] c_PHASE_UP   = 2'b10;
    localparam logic [1:0] c_PHASE_DOWN = 2'b01;

    // Majority over the low nsamp bits: 1 iff more than half are set
    function automatic logic majority(input logic [c_SAMP_W-1:0] samples,
                                      input int                  nsamp);
        int ones;
        ones = 0;
        for (int i = 0; i < c_SAMP_W; i++) begin
            if ((i < nsamp) && samples[i]) begin
                ones = ones + 1;
            end
        end
        return (ones > (nsamp / 2));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdr_sample_timer.sv
`default_nettype none
// ============================================================================
// Module : cdr_sample_timer
// Brief  : Sample-instant generator. A down-counter emits s_en for one cycle
//          when it reaches zero and reloads. A pending phase correction
//          shortens (up) or lengthens (down) exactly one reload interval.
// Ports  : CLOCK_10 - clock, rising edge
//          reset    - synchronous, active-high
//          up       - one-cycle request to shorten the next reload by STEP
//          down     - one-cycle request to lengthen the next reload by STEP
//          s_en     - one-cycle sample strobe
// Rev    : 1.0  initial release
// ============================================================================
module cdr_sample_timer
    import cdr_pkg::*;
#(
    parameter int SPACING = 332,
    parameter int STEP    = 111
) (
    input  logic CLOCK_10,
    input  logic reset,
    input  logic up,
    input  logic down,
    output logic s_en
);

    localparam int c_TW = $clog2(SPACING + STEP + 1);

    localparam logic [c_TW-1:0] c_RELOAD_NOM = c_TW'(SPACING);
    localparam logic [c_TW-1:0] c_RELOAD_UP  = c_TW'(SPACING - STEP);
    localparam logic [c_TW-1:0] c_RELOAD_DN  = c_TW'(SPACING + STEP);
    localparam logic [c_TW-1:0] c_ONE        = c_TW'(1);

    logic [c_TW-1:0] r_timer;
    logic            r_pend_up;
    logic            r_pend_dn;

    assign s_en = (r_timer == '0);

    always_ff @(posedge CLOCK_10) begin
        if (reset) begin
            r_timer   <= c_RELOAD_NOM;
            r_pend_up <= 1'b0;
            r_pend_dn <= 1'b0;
        end else begin
            if (s_en) begin
                if (r_pend_up) begin
                    r_timer <= c_RELOAD_UP;
                end else if (r_pend_dn) begin
                    r_timer <= c_RELOAD_DN;
                end else begin
                    r_timer <= c_RELOAD_NOM;
                end
            end else begin
                r_timer <= r_timer - c_ONE;
            end

            // A fresh decision replaces whatever is pending; otherwise the
            // reload that just used the pending value retires it.
            if (up) begin
                r_pend_up <= 1'b1;
                r_pend_dn <= 1'b0;
            end else if (down) begin
                r_pend_up <= 1'b0;
                r_pend_dn <= 1'b1;
            end else if (s_en) begin
                r_pend_up <= 1'b0;
                r_pend_dn <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdr_ovs.sv
`default_nettype none
// ============================================================================
// Module : cdr_ovs
// Brief  : Oversampling clock/data recovery. Takes NSAMP samples per bit,
//          decides the bit by majority vote, steers the sample phase from
//          the edge samples and tracks lock.
// Ports  : CLOCK_10  - clock, rising edge
//          reset     - synchronous, active-high
//          dat_in    - serial data (already synchronised)
//          dat_out   - recovered bit, held between strobes
//          En_out    - one-cycle strobe, dat_out updated in the same cycle
//          locked    - high while LOCK_CNT uncorrected bits have been seen
//          phase_adj - {up, down} correction pulse, only in En_out cycles
// Rev    : 1.0  initial release
// ============================================================================
module cdr_ovs
    import cdr_pkg::*;
#(
    parameter int BIT_CLKS = c_BIT_CLKS_DEFAULT,
    parameter int NSAMP    = c_NSAMP_DEFAULT,
    parameter int STEP     = c_STEP_DEFAULT,
    parameter int LOCK_CNT = c_LOCK_CNT_DEFAULT
) (
    input  logic       CLOCK_10,
    input  logic       reset,
    input  logic       dat_in,
    output logic       dat_out,
    output logic       En_out,
    output logic       locked,
    output logic [1:0] phase_adj
);

    localparam int c_SPACING = BIT_CLKS / NSAMP - 1;
    localparam int c_IW      = $clog2(NSAMP);
    localparam int c_LW      = $clog2(LOCK_CNT + 1);

    localparam logic [c_IW-1:0] c_IDX_TOP  = c_IW'(NSAMP - 1);
    localparam logic [c_IW-1:0] c_IDX_ONE  = c_IW'(1);
    localparam logic [c_LW-1:0] c_LOCK_MAX = c_LW'(LOCK_CNT);
    localparam logic [c_LW-1:0] c_LOCK_ONE = c_LW'(1);

    // Elaboration guards on the parameter set
    generate
        if (STEP >= c_SPACING) begin : g_bad_step
            $error("cdr_ovs: STEP must be smaller than BIT_CLKS/NSAMP - 1");
        end
        if ((NSAMP < 3) || (NSAMP > c_MAX_NSAMP) || ((NSAMP % 2) == 0)) begin : g_bad_nsamp
            $error("cdr_ovs: NSAMP must be odd and within 3..7");
        end
    endgenerate

    logic                r_d_en;
    logic [NSAMP-1:0]    r_samp;
    logic [c_IW-1:0]     r_idx;
    logic [c_LW-1:0]     r_lock_cnt;

    logic                w_s_en;
    logic                w_maj;
    logic                w_up;
    logic                w_dn;
    logic [c_SAMP_W-1:0] w_samp_ext;

    cdr_sample_timer #(
        .SPACING (c_SPACING),
        .STEP    (STEP)
    ) u_timer (
        .CLOCK_10 (CLOCK_10),
        .reset    (reset),
        .up       (w_up),
        .down     (w_dn),
        .s_en     (w_s_en)
    );

    assign w_samp_ext = {{(c_SAMP_W - NSAMP){1'b0}}, r_samp};
    assign w_maj      = majority(w_samp_ext, NSAMP);

    // Bit 0 is the newest sample, the MSB the oldest. A disagreeing newest
    // sample means the edge arrived early in the window -> sample sooner.
    assign w_up = r_d_en && (r_samp[0] != w_maj) && (r_samp[NSAMP-1] == w_maj);
    assign w_dn = r_d_en && (r_samp[NSAMP-1] != w_maj) && (r_samp[0] == w_maj);

    always_ff @(posedge CLOCK_10) begin
        if (reset) begin
            r_samp     <= '0;
            r_idx      <= c_IDX_TOP;
            r_d_en     <= 1'b0;
            r_lock_cnt <= '0;
            dat_out    <= 1'b0;
            En_out     <= 1'b0;
            locked     <= 1'b0;
            phase_adj  <= c_PHASE_NONE;
        end else begin
            if (w_s_en) begin
                r_samp <= {r_samp[NSAMP-2:0], dat_in};
                r_idx  <= (r_idx == '0) ? c_IDX_TOP : (r_idx - c_IDX_ONE);
            end

            // Decision runs one cycle after the last sample has been shifted in
            r_d_en <= w_s_en && (r_idx == '0);

            En_out    <= r_d_en;
            phase_adj <= r_d_en ? {w_up, w_dn} : c_PHASE_NONE;

            if (r_d_en) begin
                dat_out <= w_maj;
                if (w_up || w_dn) begin
                    r_lock_cnt <= '0;
                end else if (r_lock_cnt != c_LOCK_MAX) begin
                    r_lock_cnt <= r_lock_cnt + c_LOCK_ONE;
                end
            end

            // Registered from the counter, so it trails a correction by a cycle
            locked <= (r_lock_cnt == c_LOCK_MAX);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdr_ovs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_cdr_ovs
// Brief  : Self-checking bench for cdr_ovs. Two instances (defaults, and
//          NSAMP=5/BIT_CLKS=1000) are compared every cycle against an
//          event-scheduled model of sample instants and bit decisions, plus
//          directed literal expectations on latency, intervals and lock.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cdr_ovs;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic din0 = 1'b0;
    logic din1 = 1'b0;

    logic       dout0, en0, lock0;
    logic [1:0] padj0;
    logic       dout1, en1, lock1;
    logic [1:0] padj1;

    always #5 clk = ~clk;

    cdr_ovs u_dut0 (
        .CLOCK_10 (clk), .reset (rst), .dat_in (din0),
        .dat_out (dout0), .En_out (en0), .locked (lock0), .phase_adj (padj0)
    );

    cdr_ovs #(.BIT_CLKS(1000), .NSAMP(5), .STEP(50), .LOCK_CNT(16)) u_dut1 (
        .CLOCK_10 (clk), .reset (rst), .dat_in (din1),
        .dat_out (dout1), .En_out (en1), .locked (lock1), .phase_adj (padj1)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int         ns, spacing, step, lockc;
        int         next_edge;   // clock edge at which the next sample is taken
        int         cnt;         // samples gathered for current bit
        logic [7:0] samp;
        int         pend;        // 0 none, 1 up, 2 down
        int         out_edge, lock_edge;
        logic       q_dat;
        logic [1:0] q_padj;
        int         lock_n;
        logic       o_dat, o_en, o_locked;
        logic [1:0] o_padj;
    } model_t;

    model_t m [2];
    int     k = 0;           // number of rising edges so far
    int     n_checks = 0;
    int     n_err = 0;
    int     k_rel = 0;
    bit     released = 1'b0;
    bit     q0 [$];
    bit     q1 [$];

    task automatic model_step(input int i, input logic r, input logic d);
        int   intv, pc;
        logic maj, up, dn;
        m[i].o_en   = 1'b0;
        m[i].o_padj = 2'b00;
        if (r) begin
            m[i].next_edge = k + m[i].spacing + 1;
            m[i].cnt       = 0;
            m[i].samp      = '0;
            m[i].pend      = 0;
            m[i].out_edge  = -1;
            m[i].lock_edge = -1;
            m[i].lock_n    = 0;
            m[i].o_dat     = 1'b0;
            m[i].o_locked  = 1'b0;
        end else begin
            if (k == m[i].out_edge) begin
                m[i].o_en   = 1'b1;
                m[i].o_dat  = m[i].q_dat;
                m[i].o_padj = m[i].q_padj;
            end
            if (k == m[i].lock_edge) m[i].o_locked = (m[i].lock_n == m[i].lockc);
            if (k == m[i].next_edge) begin
                m[i].samp = {m[i].samp[6:0], d};
                m[i].cnt++;
                intv = m[i].spacing + 1;
                if (m[i].pend == 1) intv = intv - m[i].step;
                if (m[i].pend == 2) intv = intv + m[i].step;
                m[i].pend      = 0;
                m[i].next_edge = k + intv;
                if (m[i].cnt == m[i].ns) begin
                    pc = 0;
                    for (int b = 0; b < m[i].ns; b++) pc += int'(m[i].samp[b]);
                    maj = (pc > m[i].ns / 2);
                    up  = (m[i].samp[0] != maj) && (m[i].samp[m[i].ns-1] == maj);
                    dn  = (m[i].samp[m[i].ns-1] != maj) && (m[i].samp[0] == maj);
                    m[i].q_dat     = maj;
                    m[i].q_padj    = {up, dn};
                    m[i].out_edge  = k + 1;
                    m[i].lock_edge = k + 2;
                    if (up || dn) begin
                        m[i].lock_n = 0;
                        m[i].pend   = up ? 1 : 2;
                    end else if (m[i].lock_n < m[i].lockc) begin
                        m[i].lock_n++;
                    end
                    m[i].cnt = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, k);
        end
    endtask

    // ---------------- compare process ----------------
    logic mon_r, mon_d0, mon_d1;
    always @(posedge clk) begin
        mon_r  = rst;
        mon_d0 = din0;
        mon_d1 = din1;
        k = k + 1;
        model_step(0, mon_r, mon_d0);
        model_step(1, mon_r, mon_d1);
        #1;
        chk("dat_out0",   32'(dout0), 32'(m[0].o_dat));
        chk("En_out0",    32'(en0),   32'(m[0].o_en));
        chk("locked0",    32'(lock0), 32'(m[0].o_locked));
        chk("phase_adj0", 32'(padj0), 32'(m[0].o_padj));
        chk("dat_out1",   32'(dout1), 32'(m[1].o_dat));
        chk("En_out1",    32'(en1),   32'(m[1].o_en));
        chk("locked1",    32'(lock1), 32'(m[1].o_locked));
        chk("phase_adj1", 32'(padj1), 32'(m[1].o_padj));
    end

    // ---------------- data driver ----------------
    // Queued values land exactly on sample edges; noise fills the rest.
    always @(negedge clk) begin
        if ((m[0].next_edge == k + 1) && (q0.size() > 0)) din0 = q0.pop_front();
        else                                               din0 = 1'($urandom_range(0, 1));
        if ((m[1].next_edge == k + 1) && (q1.size() > 0)) din1 = q1.pop_front();
        else                                               din1 = 1'($urandom_range(0, 1));
    end

    task automatic push_bit(input int i, input bit [6:0] pat, input int ns);
        // pat[ns-1] is the first (oldest) sample
        for (int b = ns - 1; b >= 0; b--) begin
            if (i == 0) q0.push_back(pat[b]);
            else        q1.push_back(pat[b]);
        end
    endtask

    task automatic wait_en(input int i, input int budget, output int ek,
                           output logic d, output logic [1:0] pa, output logic lk);
        ek = -1; d = 1'b0; pa = 2'b00; lk = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((i == 0) ? en0 : en1) begin
                ek = k;
                d  = (i == 0) ? dout0 : dout1;
                pa = (i == 0) ? padj0 : padj1;
                lk = (i == 0) ? lock0 : lock1;
                break;
            end
        end
        if (ek < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_en%0d: no strobe within %0d cycles", i, budget);
        end
    endtask

    // ---------------- instance 1 (NSAMP=5) directed checks ----------------
    initial begin
        int         ek, prev;
        logic       d, lk;
        logic [1:0] pa;
        wait (released);
        wait_en(1, 1200, ek, d, pa, lk);
        chk("n5_first_lat", 32'(ek - k_rel), 32'd1001);
        chk("n5_00011_dat", 32'(d), 32'd0);
        chk("n5_00011_adj", 32'(pa), 32'b10);
        prev = ek;
        wait_en(1, 1200, ek, d, pa, lk);
        chk("n5_short_bit", 32'(ek - prev), 32'd950);
        chk("n5_11011_dat", 32'(d), 32'd1);
        chk("n5_11011_adj", 32'(pa), 32'b00);
    end

    // ---------------- main sequence ----------------
    initial begin
        int         ek, prev, n;
        logic       d, lk;
        logic [1:0] pa;

        m[0].ns = 3; m[0].spacing = 332; m[0].step = 111; m[0].lockc = 16;
        m[1].ns = 5; m[1].spacing = 199; m[1].step = 50;  m[1].lockc = 16;

        repeat (5) @(negedge clk);
        chk("rst_dat_out", 32'(dout0), 32'd0);
        chk("rst_En_out",  32'(en0),   32'd0);
        chk("rst_locked",  32'(lock0), 32'd0);
        chk("rst_phase",   32'(padj0), 32'd0);

        for (int b = 0; b < 17; b++) push_bit(0, 7'b111, 3);
        push_bit(0, 7'b001, 3);
        push_bit(0, 7'b111, 3);
        push_bit(0, 7'b011, 3);
        push_bit(0, 7'b010, 3);
        push_bit(0, 7'b101, 3);
        push_bit(1, 7'b00011, 5);
        push_bit(1, 7'b11011, 5);

        rst = 1'b0;
        k_rel = k;
        released = 1'b1;

        // constant ones: latency, 999-clock strobes, lock after 16
        wait_en(0, 1100, ek, d, pa, lk);
        chk("first_lat", 32'(ek - k_rel), 32'd1000);
        chk("first_dat", 32'(d), 32'd1);
        prev = ek;
        for (int b = 2; b <= 17; b++) begin
            wait_en(0, 1200, ek, d, pa, lk);
            chk("ones_period", 32'(ek - prev), 32'd999);
            if (b == 16) chk("lock_at16", 32'(lk), 32'd0);
            if (b == 17) chk("lock_at17", 32'(lk), 32'd1);
            prev = ek;
        end

        // 001 -> up, lock drops one cycle after strobe
        wait_en(0, 1200, ek, d, pa, lk);
        chk("p001_dat", 32'(d), 32'd0);
        chk("p001_adj", 32'(pa), 32'b10);
        chk("p001_lock_strobe", 32'(lk), 32'd1);
        @(negedge clk);
        chk("p001_lock_after", 32'(lock0), 32'd0);
        chk("p001_adj_after", 32'(padj0), 32'd0);
        prev = ek;
        wait_en(0, 1200, ek, d, pa, lk);
        chk("short_period", 32'(ek - prev), 32'd888);
        prev = ek;
        // 011 -> down
        wait_en(0, 1200, ek, d, pa, lk);
        chk("p011_period", 32'(ek - prev), 32'd999);
        chk("p011_dat", 32'(d), 32'd1);
        chk("p011_adj", 32'(pa), 32'b01);
        prev = ek;
        // 010, 101 -> no correction
        wait_en(0, 1300, ek, d, pa, lk);
        chk("long_period", 32'(ek - prev), 32'd1110);
        chk("p010_dat", 32'(d), 32'd0);
        chk("p010_adj", 32'(pa), 32'b00);
        prev = ek;
        wait_en(0, 1200, ek, d, pa, lk);
        chk("p101_period", 32'(ek - prev), 32'd999);
        chk("p101_dat", 32'(d), 32'd1);
        chk("p101_adj", 32'(pa), 32'b00);

        // random bits, checked by the model
        for (int b = 0; b < 45; b++) q0.push_back(1'($urandom_range(0, 1)));
        for (int b = 0; b < 15; b++) wait_en(0, 1300, ek, d, pa, lk);

        // reset after two samples of a bit
        for (n = 0; (n < 1300) && (m[0].cnt != 2); n++) @(negedge clk);
        chk("partial_reached", 32'(m[0].cnt), 32'd2);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_En_out", 32'(en0), 32'd0);
        chk("midrst_dat_out", 32'(dout0), 32'd0);
        chk("midrst_locked", 32'(lock0), 32'd0);
        for (int b = 0; b < 2; b++) push_bit(0, 7'b111, 3);
        rst = 1'b0;
        k_rel = k;
        wait_en(0, 1100, ek, d, pa, lk);
        chk("midrst_lat", 32'(ek - k_rel), 32'd1000);
        chk("midrst_dat", 32'(d), 32'd1);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
